// File: rtl/byte_striping_controller.sv
// Round-robin byte striper onto x1/x2/x4 lanes; lane outputs registered, 1-cycle latency.
// byteRDY follows laneRDY of the current lane; short final sets are padded before IDLE.
module byte_striping_controller #(
  parameter logic [7:0] PAD_SYMBOL = 8'hF7,
  parameter int         SETCNT_W   = 16
) (
  input  logic                clk1Mhz,
  input  logic                resetL,
  input  logic                enable,
  input  logic [1:0]          laneMode,
  input  logic [7:0]          byteStripingIN,
  input  logic                byteVLD,
  input  logic                byteEND,
  input  logic [3:0]          laneRDY,
  output logic                byteRDY,
  output logic [7:0]          stripedLane0,
  output logic [7:0]          stripedLane1,
  output logic [7:0]          stripedLane2,
  output logic [7:0]          stripedLane3,
  output logic [3:0]          laneLoad,
  output logic                byteStripingVLD,
  output logic [1:0]          laneIdx,
  output logic                modeErr,
  output logic [SETCNT_W-1:0] setCount
);

  typedef enum logic [1:0] {IDLE, STRIPE, PAD} state_t;

  state_t     state, state_nxt;
  logic [1:0] last_idx, last_nxt;   // index of the highest active lane (N-1)
  logic [1:0] idx_nxt;
  logic       wr_en;
  logic [7:0] wr_dat;
  logic       set_done;
  logic       err_set;

  always_comb begin
    state_nxt = state;
    last_nxt  = last_idx;
    idx_nxt   = laneIdx;
    wr_en     = 1'b0;
    wr_dat    = byteStripingIN;
    set_done  = 1'b0;
    err_set   = 1'b0;
    byteRDY   = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt = STRIPE;
          case (laneMode)
            2'b00:   last_nxt = 2'd0;
            2'b01:   last_nxt = 2'd1;
            2'b10:   last_nxt = 2'd3;
            default: begin
              last_nxt = 2'd0;
              err_set  = 1'b1;
            end
          endcase
        end
      end
      STRIPE: begin
        byteRDY = laneRDY[laneIdx];
        if (byteVLD && laneRDY[laneIdx]) begin
          wr_en = 1'b1;
          if (laneIdx == last_idx) begin
            idx_nxt  = 2'd0;
            set_done = 1'b1;
            if (byteEND) state_nxt = IDLE;
          end else begin
            idx_nxt = laneIdx + 2'd1;
            if (byteEND) state_nxt = PAD;
          end
        end else if (!enable && laneIdx == 2'd0) begin
          // Leaving only on a set boundary keeps partial sets intact.
          state_nxt = IDLE;
        end
      end
      PAD: begin
        if (laneRDY[laneIdx]) begin
          wr_en  = 1'b1;
          wr_dat = PAD_SYMBOL;
          if (laneIdx == last_idx) begin
            idx_nxt   = 2'd0;
            set_done  = 1'b1;
            state_nxt = IDLE;
          end else begin
            idx_nxt = laneIdx + 2'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk1Mhz) begin
    if (!resetL) begin
      state           <= IDLE;
      last_idx        <= 2'd0;
      laneIdx         <= 2'd0;
      stripedLane0    <= 8'h00;
      stripedLane1    <= 8'h00;
      stripedLane2    <= 8'h00;
      stripedLane3    <= 8'h00;
      laneLoad        <= 4'b0000;
      byteStripingVLD <= 1'b0;
      modeErr         <= 1'b0;
      setCount        <= '0;
    end else begin
      state           <= state_nxt;
      last_idx        <= last_nxt;
      laneIdx         <= idx_nxt;
      laneLoad        <= wr_en ? (4'b0001 << laneIdx) : 4'b0000;
      byteStripingVLD <= set_done;
      if (err_set)  modeErr  <= 1'b1;
      if (set_done) setCount <= setCount + SETCNT_W'(1);
      if (wr_en) begin
        case (laneIdx)
          2'd0:    stripedLane0 <= wr_dat;
          2'd1:    stripedLane1 <= wr_dat;
          2'd2:    stripedLane2 <= wr_dat;
          default: stripedLane3 <= wr_dat;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_byte_striping_controller.sv
// Directed and random striping against a lane-event model (lane = byte position mod N).
module tb_byte_striping_controller;

  localparam logic [7:0] PAD = 8'hF7;

  logic       clk1Mhz = 1'b0;
  logic       resetL, enable, byteVLD, byteEND;
  logic [1:0] laneMode;
  logic [7:0] byteStripingIN;
  logic [3:0] laneRDY;
  logic       byteRDY, byteStripingVLD, modeErr;
  logic [7:0] stripedLane0, stripedLane1, stripedLane2, stripedLane3;
  logic [3:0] laneLoad;
  logic [1:0] laneIdx;
  logic [3:0] setCount;

  byte_striping_controller #(.PAD_SYMBOL(PAD), .SETCNT_W(4)) dut (
    .clk1Mhz(clk1Mhz), .resetL(resetL), .enable(enable), .laneMode(laneMode),
    .byteStripingIN(byteStripingIN), .byteVLD(byteVLD), .byteEND(byteEND),
    .laneRDY(laneRDY), .byteRDY(byteRDY),
    .stripedLane0(stripedLane0), .stripedLane1(stripedLane1),
    .stripedLane2(stripedLane2), .stripedLane3(stripedLane3),
    .laneLoad(laneLoad), .byteStripingVLD(byteStripingVLD), .laneIdx(laneIdx),
    .modeErr(modeErr), .setCount(setCount)
  );

  always #500 clk1Mhz = ~clk1Mhz;

  int n_assert = 0, n_fail = 0, anomaly = 0;
  int exp_cnt = 0, pos = 0, pkt_n = 1;
  bit exp_err = 0, mon_on = 0;
  logic [7:0]  exp_lane [4];
  logic [10:0] exp_q[$], obs_q[$];

  function automatic logic [7:0] lane_val(input int i);
    case (i)
      0:       return stripedLane0;
      1:       return stripedLane1;
      2:       return stripedLane2;
      default: return stripedLane3;
    endcase
  endfunction

  // Every load becomes {set-complete flag, lane, data}.
  always @(negedge clk1Mhz) begin
    if (mon_on) begin
      if (laneLoad != 4'b0000) begin
        if ($countones(laneLoad) != 1) anomaly++;
        for (int i = 0; i < 4; i++)
          if (laneLoad[i]) obs_q.push_back({byteStripingVLD, 2'(i), lane_val(i)});
      end else if (byteStripingVLD) begin
        anomaly++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_put(input logic [7:0] d);
    int lane;
    lane = pos % pkt_n;
    exp_q.push_back({lane == pkt_n - 1, 2'(lane), d});
    exp_lane[lane] = d;
    pos++;
    if (pos == pkt_n) begin
      pos = 0;
      exp_cnt++;
    end
  endtask

  task automatic begin_pkt(input logic [1:0] m);
    laneMode = m;
    enable   = 1'b1;
    pkt_n    = (m == 2'b01) ? 2 : (m == 2'b10) ? 4 : 1;
    if (m == 2'b11) exp_err = 1;
  endtask

  task automatic send(input logic [7:0] d, input logic e, input bit rnd);
    bit took = 0;
    byteStripingIN = d;
    byteEND        = e;
    byteVLD        = 1'b1;
    for (int c = 0; c < 200 && !took; c++) begin
      if (rnd) laneRDY = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      @(negedge clk1Mhz);
      took = (byteRDY === 1'b1);
      @(posedge clk1Mhz);
      #1;
    end
    byteVLD = 1'b0;
    byteEND = 1'b0;
    chk("send_accept", 32'(took), 32'd1);
    if (took) begin
      model_put(d);
      if (e) while (pos != 0) model_put(PAD);
    end
  endtask

  task automatic check_events(input string tag);
    chk({tag, "_ev_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      chk({tag, "_ev"}, 32'(obs_q[i]), 32'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  // Drain pad/stripe activity, park in IDLE and compare everything against the model.
  task automatic flush_check(input string tag);
    enable  = 1'b0;
    byteVLD = 1'b0;
    laneRDY = 4'hF;
    repeat (8) @(posedge clk1Mhz);
    @(negedge clk1Mhz);
    check_events(tag);
    for (int i = 0; i < 4; i++) chk({tag, "_lane"}, 32'(lane_val(i)), 32'(exp_lane[i]));
    chk({tag, "_setCount"}, 32'(setCount), 32'(exp_cnt % 16));
    chk({tag, "_modeErr"}, 32'(modeErr), 32'(exp_err));
    chk({tag, "_laneIdx"}, 32'(laneIdx), 32'd0);
    chk({tag, "_idle_rdy"}, 32'(byteRDY), 32'd0);
    @(posedge clk1Mhz);
    #1;
  endtask

  task automatic reset_model();
    for (int i = 0; i < 4; i++) exp_lane[i] = 8'h00;
    exp_cnt = 0;
    pos     = 0;
    exp_err = 0;
  endtask

  initial begin
    resetL = 1'b0; enable = 1'b0; laneMode = 2'b00; byteStripingIN = 8'h00;
    byteVLD = 1'b0; byteEND = 1'b0; laneRDY = 4'hF;
    reset_model();
    repeat (2) @(posedge clk1Mhz);
    @(negedge clk1Mhz);
    mon_on = 1;
    chk("rst_lane0", 32'(stripedLane0), 32'd0);
    chk("rst_load", 32'(laneLoad), 32'd0);
    chk("rst_vld", 32'(byteStripingVLD), 32'd0);
    chk("rst_idx", 32'(laneIdx), 32'd0);
    chk("rst_err", 32'(modeErr), 32'd0);
    chk("rst_cnt", 32'(setCount), 32'd0);
    chk("rst_rdy", 32'(byteRDY), 32'd0);
    @(posedge clk1Mhz); #1;
    resetL = 1'b1;

    // x4 full set on consecutive cycles
    begin_pkt(2'b10);
    send(8'h01, 0, 0); send(8'h02, 0, 0); send(8'h03, 0, 0); send(8'h04, 0, 0);
    @(negedge clk1Mhz);
    chk("x4_last_load", 32'(laneLoad), 32'h8);
    chk("x4_vld", 32'(byteStripingVLD), 32'd1);
    chk("x4_cnt", 32'(setCount), 32'd1);
    @(posedge clk1Mhz); #1;
    flush_check("x4_set");

    // x4 short packet padded on lanes 2,3
    begin_pkt(2'b10);
    send(8'h0A, 0, 0); send(8'h0B, 1, 0);
    @(negedge clk1Mhz);
    chk("pad_load_b", 32'(laneLoad), 32'h2);
    @(negedge clk1Mhz);
    chk("pad_load_2", 32'(laneLoad), 32'h4);
    chk("pad_rdy", 32'(byteRDY), 32'd0);
    chk("pad_novld", 32'(byteStripingVLD), 32'd0);
    @(negedge clk1Mhz);
    chk("pad_load_3", 32'(laneLoad), 32'h8);
    chk("pad_vld", 32'(byteStripingVLD), 32'd1);
    chk("pad_idle_rdy", 32'(byteRDY), 32'd0);
    @(posedge clk1Mhz); #1;
    flush_check("x4_pad");

    // x2 with lane1 stalled for 3 cycles
    begin_pkt(2'b01);
    send(8'h11, 0, 0);
    laneRDY = 4'hD; byteStripingIN = 8'h22; byteEND = 1'b1; byteVLD = 1'b1;
    repeat (3) begin
      @(negedge clk1Mhz);
      chk("stall_rdy", 32'(byteRDY), 32'd0);
      chk("stall_hold", 32'(stripedLane1), 32'(exp_lane[1]));
      @(posedge clk1Mhz); #1;
    end
    laneRDY = 4'hF;
    send(8'h22, 1, 0);
    flush_check("x2_stall");

    // illegal mode behaves as x1 and sets modeErr
    begin_pkt(2'b11);
    send(8'h31, 0, 0); send(8'h32, 0, 0); send(8'h33, 1, 0);
    flush_check("illegal");

    // reset after 3 of 4 bytes in x4
    begin_pkt(2'b10);
    send(8'h41, 0, 0); send(8'h42, 0, 0); send(8'h43, 0, 0);
    resetL = 1'b0;
    @(posedge clk1Mhz);
    @(negedge clk1Mhz);
    check_events("pre_rst");
    chk("mid_rst_lane2", 32'(stripedLane2), 32'd0);
    chk("mid_rst_load", 32'(laneLoad), 32'd0);
    chk("mid_rst_vld", 32'(byteStripingVLD), 32'd0);
    chk("mid_rst_idx", 32'(laneIdx), 32'd0);
    chk("mid_rst_err", 32'(modeErr), 32'd0);
    chk("mid_rst_cnt", 32'(setCount), 32'd0);
    @(posedge clk1Mhz); #1;
    resetL = 1'b1;
    reset_model();
    begin_pkt(2'b10);
    send(8'h51, 0, 0); send(8'h52, 0, 0); send(8'h53, 0, 0); send(8'h54, 1, 0);
    flush_check("restart");

    // laneMode change and enable drop mid-packet are ignored until IDLE
    begin_pkt(2'b10);
    send(8'h61, 0, 0);
    laneMode = 2'b01;
    enable   = 1'b0;
    send(8'h62, 0, 0); send(8'h63, 0, 0); send(8'h64, 0, 0);
    enable = 1'b1;
    send(8'h65, 0, 0); send(8'h66, 1, 0);
    flush_check("mode_hold");
    begin_pkt(2'b01);
    send(8'h71, 0, 0); send(8'h72, 0, 0); send(8'h73, 1, 0);
    flush_check("mode_new");

    // random packets with random lane backpressure
    for (int p = 0; p < 24; p++) begin
      int len;
      begin_pkt(2'($urandom_range(0, 3)));
      len = $urandom_range(1, 9);
      for (int k = 0; k < len; k++) send(8'($urandom), k == len - 1, 1);
    end
    flush_check("random");

    // 16 single-lane sets wrap the 4-bit counter back to its start value
    for (int k = 0; k < 16; k++) begin
      begin_pkt(2'b00);
      send(8'($urandom), 1, 0);
    end
    flush_check("wrap16");

    chk("protocol_anomalies", 32'(anomaly), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
